// File: rtl/soc_system_sysid_pkg.sv
// Shared types and helpers for the sysid boot checker and its timeout counter.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WT_ID,
    RD_TS,
    WT_TS,
    BACKOFF,
    FIN
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/soc_system_sysid_timeout_cnt.sv
// Per-word watchdog: clear on entry, count while enabled, flag the last allowed cycle.
module soc_system_sysid_timeout_cnt
  import soc_system_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned WIDTH = clog2(LIMIT)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Boot-time sysid reader: fetches ID and build timestamp over Avalon-MM and latches match results.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h5288FA6A,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e r_state, w_next, w_tmo_state;
  logic         r_auto_pend;
  logic [2:0]   r_retry;
  logic         r_id_ok, r_ts_ok, r_timeout_err;
  logic [31:0]  r_id_value, r_ts_value;
  logic         w_seq_start, w_retry_inc, w_set_to, w_cap_id, w_cap_ts;
  logic         w_cnt_clr, w_cnt_en, w_expired, w_can_retry;

  soc_system_sysid_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk    (clock),
    .i_rst_n  (reset_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expired(w_expired)
  );

  assign w_can_retry = (r_retry < 3'(MAX_RETRY));
  assign w_tmo_state = w_can_retry ? BACKOFF : FIN;

  // Data in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_next      = r_state;
    w_seq_start = 1'b0;
    w_retry_inc = 1'b0;
    w_set_to    = 1'b0;
    w_cap_id    = 1'b0;
    w_cap_ts    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start || r_auto_pend) begin
          w_next      = RD_ID;
          w_seq_start = 1'b1;
        end
      end
      RD_ID: begin
        if (w_expired)             w_next = w_tmo_state;
        else if (!avm_waitrequest) w_next = WT_ID;
      end
      WT_ID: begin
        if (avm_readdatavalid) begin
          w_next   = RD_TS;
          w_cap_id = 1'b1;
        end else if (w_expired) begin
          w_next = w_tmo_state;
        end
      end
      RD_TS: begin
        if (w_expired)             w_next = w_tmo_state;
        else if (!avm_waitrequest) w_next = WT_TS;
      end
      WT_TS: begin
        if (avm_readdatavalid) begin
          w_next   = FIN;
          w_cap_ts = 1'b1;
        end else if (w_expired) begin
          w_next = w_tmo_state;
        end
      end
      BACKOFF: w_next = RD_ID;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_expired && w_next == w_tmo_state && r_state != w_tmo_state &&
        r_state inside {RD_ID, WT_ID, RD_TS, WT_TS}) begin
      w_retry_inc = w_can_retry;
      w_set_to    = !w_can_retry;
    end
  end

  assign w_cnt_en  = r_state inside {RD_ID, WT_ID, RD_TS, WT_TS};
  assign w_cnt_clr = (w_next == RD_ID && r_state != RD_ID) ||
                     (w_next == RD_TS && r_state != RD_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_auto_pend   <= (AUTO_START != 0);
      r_retry       <= '0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_id_value    <= '0;
      r_ts_value    <= '0;
    end else begin
      r_state     <= w_next;
      r_auto_pend <= 1'b0;
      if (w_seq_start) begin
        r_retry       <= '0;
        r_id_ok       <= 1'b0;
        r_ts_ok       <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (w_retry_inc) r_retry <= r_retry + 3'd1;
      if (w_set_to)    r_timeout_err <= 1'b1;
      if (w_cap_id) begin
        r_id_value <= avm_readdata;
        r_id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= avm_readdata;
        r_ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
    end
  end

  assign avm_read    = (r_state == RD_ID) || (r_state == RD_TS);
  assign avm_address = (r_state == RD_TS || r_state == WT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FIN);
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout_err = r_timeout_err;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Scoreboarded bench: slave model with configurable stall/latency, sequence-level reference model.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h5288FA6A;
  localparam int T = 8;
  localparam int R = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  soc_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY(R),
    .AUTO_START(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        id_ok, ts_ok, to;
    logic [31:0] id_v, ts_v;
    int          len, n0, n1;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  int          cfg_ws, cfg_lat0, cfg_lat1;
  logic [31:0] cfg_id, cfg_ts;
  logic [31:0] m_id_v, m_ts_v;
  logic        m_id_ok, m_ts_ok, m_to;
  int          stray_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Sequence-level outcome: a word succeeds when stall+accept+latency fits the window.
  task automatic push_expect();
    exp_t e;
    int c0, c1;
    bit f0, f1;
    c0 = cfg_ws + 1 + cfg_lat0;
    c1 = cfg_ws + 1 + cfg_lat1;
    f0 = (cfg_lat0 != 0) && (c0 <= T);
    f1 = (cfg_lat1 != 0) && (c1 <= T);
    m_id_ok = 1'b0; m_ts_ok = 1'b0; m_to = 1'b0;
    if (!f0) begin
      m_to = 1'b1;
      e.len = (R + 1) * T + R + 1; e.n0 = R + 1; e.n1 = 0;
    end else if (!f1) begin
      m_to = 1'b1;
      m_id_v = cfg_id; m_id_ok = (cfg_id == EXP_ID);
      e.len = (R + 1) * (c0 + T) + R + 1; e.n0 = R + 1; e.n1 = R + 1;
    end else begin
      m_id_v = cfg_id; m_id_ok = (cfg_id == EXP_ID);
      m_ts_v = cfg_ts; m_ts_ok = (cfg_ts == EXP_TS);
      e.len = c0 + c1 + 1; e.n0 = 1; e.n1 = 1;
    end
    e.id_ok = m_id_ok; e.ts_ok = m_ts_ok; e.to = m_to;
    e.id_v = m_id_v; e.ts_v = m_ts_v;
    exp_q.push_back(e);
  endtask

  // Slave: drives inputs on the falling edge from the command it sees.
  initial begin
    int stall, pcnt, stray_done, lat;
    bit pend;
    logic [31:0] pdata;
    stall = 0; pcnt = 0; pend = 0; pdata = '0; stray_done = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      if (!reset_n) begin
        stall = 0; pend = 0; avm_waitrequest = 1'b0;
        continue;
      end
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          avm_readdatavalid = 1'b1; avm_readdata = pdata; pend = 0;
        end
      end else if (stray_req != stray_done && !avm_read) begin
        avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
        stray_done++;
      end
      if (avm_read) begin
        if (stall < cfg_ws) begin
          avm_waitrequest = 1'b1; stall++;
        end else begin
          avm_waitrequest = 1'b0; stall = 0;
          lat = avm_address ? cfg_lat1 : cfg_lat0;
          if (lat != 0) begin
            pend = 1; pcnt = lat; pdata = avm_address ? cfg_ts : cfg_id;
          end
        end
      end else begin
        avm_waitrequest = 1'b0; stall = 0;
      end
    end
  end

  // Monitor: counts accepted reads and busy cycles, scores each done pulse.
  initial begin
    int len, n0, n1;
    logic p_rd, p_wr, p_addr;
    exp_t e;
    len = 0; n0 = 0; n1 = 0; p_rd = 0; p_wr = 0; p_addr = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        len = 0; n0 = 0; n1 = 0; p_rd = 0; p_wr = 0;
        continue;
      end
      if (p_rd && p_wr) begin
        chk("stall_read_hold", 32'(avm_read), 32'd1);
        chk("stall_addr_hold", 32'(avm_address), 32'(p_addr));
      end
      p_rd = avm_read; p_wr = avm_waitrequest; p_addr = avm_address;
      if (avm_read && !avm_waitrequest) begin
        if (avm_address) n1++; else n0++;
      end
      if (busy) len++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("id_ok", 32'(id_ok), 32'(e.id_ok));
          chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
          chk("timeout_err", 32'(timeout_err), 32'(e.to));
          chk("id_value", id_value, e.id_v);
          chk("ts_value", ts_value, e.ts_v);
          chk("busy_cycles", 32'(len), 32'(e.len));
          chk("reads_addr0", 32'(n0), 32'(e.n0));
          chk("reads_addr1", 32'(n1), 32'(e.n1));
        end
        len = 0; n0 = 0; n1 = 0;
      end
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("wait_bound", 32'd0, 32'd1);
  endtask

  task automatic run_seq();
    push_expect();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done();
  endtask

  task automatic set_cfg(input int ws, input int l0, input int l1,
                         input logic [31:0] id, input logic [31:0] ts);
    cfg_ws = ws; cfg_lat0 = l0; cfg_lat1 = l1; cfg_id = id; cfg_ts = ts;
  endtask

  function automatic int pick_lat(input int ws);
    if ($urandom_range(0, 5) == 0) return 0;
    return int'($urandom_range(1, T - ws));
  endfunction

  task automatic check_rst_outputs(input string name);
    chk(name, {25'd0, avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err}, 32'd0);
    chk({name, "_values"}, id_value | ts_value, 32'd0);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; start = 1'b0;
    m_id_v = '0; m_ts_v = '0;
    set_cfg(0, 1, 1, EXP_ID, EXP_TS);
    #2;
    check_rst_outputs("reset_state");

    // Auto-start after reset release: done expected 5 cycles later.
    push_expect();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_done();

    set_cfg(0, 1, 1, 32'h00000001, EXP_TS); run_seq();
    set_cfg(3, 4, 4, EXP_ID, EXP_TS);       run_seq();
    set_cfg(0, 0, 0, EXP_ID, EXP_TS);       run_seq();
    set_cfg(1, 2, 0, EXP_ID, EXP_TS);       run_seq();
    set_cfg(2, T - 2, 1, EXP_ID, EXP_TS);   run_seq();

    // Start pulses while busy, including the FIN cycle, must be dropped.
    set_cfg(0, 3, 2, EXP_ID, 32'h12345678);
    push_expect();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        seen = 1;
        break;
      end
      start = (i % 3 == 0);
    end
    start = 1'b0;
    chk("busy_start_done_seen", 32'(seen), 32'd1);
    chk("no_restart_after_fin", 32'(busy), 32'd0);

    stray_req++;
    repeat (4) @(negedge clock);
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_id_value", id_value, m_id_v);
    chk("idle_stray_ts_value", ts_value, m_ts_v);
    chk("idle_stray_flags", {29'd0, id_ok, ts_ok, timeout_err}, {29'd0, m_id_ok, m_ts_ok, m_to});

    for (int n = 0; n < 20; n++) begin
      int ws;
      ws = int'($urandom_range(0, 3));
      set_cfg(ws, pick_lat(ws), pick_lat(ws),
              ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom,
              ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom);
      run_seq();
    end

    // Reset asserted during WT_TS; the bench then expects a fresh auto-run.
    set_cfg(0, 1, 5, EXP_ID, EXP_TS);
    push_expect();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busy && avm_address && !avm_read) begin seen = 1; break; end
    end
    chk("reached_wt_ts", 32'(seen), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_rst_outputs("async_reset");
    exp_q.delete();
    m_id_v = '0; m_ts_v = '0;
    set_cfg(0, 1, 1, EXP_ID, EXP_TS);
    push_expect();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_done();

    repeat (3) @(negedge clock);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
